// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage for the MIPS-subset core.
// Turns a 32-bit instruction into a registered control/operand bundle. It adds:
//   - a valid/ready handshake with fetch
//   - a one-bubble load-use interlock
//   - optional squashing of the slot after J/JAL/JR
//   - external stall and flush
//
// Parameters
//   WIDTH       datapath width (>= 32); imm is extended to this width
//   DELAY_SLOT  1: execute the instruction after a jump, 0: squash it
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   instr, instrValid   instruction from fetch and its valid flag
//   instrReady          combinational; instr consumed when valid && ready
//   stall, flush        downstream hold / kill
//   outValid            registered bundle holds a real instruction
//   op, pcSrcCtrl, regDInCtrl, regWe, dmWe, dmRe, aluBSrcCtrl
//                       registered control fields
//   regWAddr, rs, rt, imm, jAddr
//                       registered operand fields
//   illegal             registered slot came from an unrecognised opcode/funct
//
// Squash state machine (only reachable when DELAY_SLOT == 0)
//   state     | meaning
//   S_RUN     | normal decode
//   S_SQUASH  | a jump is registered; the next accepted instr becomes a bubble
module decode_stage #(
  parameter int WIDTH      = 32,
  parameter int DELAY_SLOT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             instrValid,
  output logic             instrReady,
  input  logic             stall,
  input  logic             flush,
  output logic             outValid,
  output logic [2:0]       op,
  output logic [1:0]       pcSrcCtrl,
  output logic [1:0]       regDInCtrl,
  output logic             regWe,
  output logic             dmWe,
  output logic             dmRe,
  output logic             aluBSrcCtrl,
  output logic [4:0]       regWAddr,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [WIDTH-1:0] imm,
  output logic [25:0]      jAddr,
  output logic             illegal
);

  localparam bit SQUASH_EN = (DELAY_SLOT == 0);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_XORI  = 6'h0e;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  localparam logic [1:0] PC_INC4 = 2'd0;
  localparam logic [1:0] PC_J    = 2'd1;
  localparam logic [1:0] PC_JR   = 2'd2;
  localparam logic [1:0] PC_BNE  = 2'd3;

  localparam logic [1:0] RD_ALU  = 2'd0;
  localparam logic [1:0] RD_DM   = 2'd1;
  localparam logic [1:0] RD_JAL  = 2'd2;

  typedef struct packed {
    logic             valid;
    logic             ill;
    logic [2:0]       op;
    logic [1:0]       pc;
    logic [1:0]       rdin;
    logic             we;
    logic             dmwe;
    logic             dmre;
    logic             alub;
    logic [4:0]       wa;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [WIDTH-1:0] imm;
    logic [25:0]      ja;
  } bundle_t;

  typedef enum logic {S_RUN, S_SQUASH} sq_state_t;

  sq_state_t state_q, state_d;
  bundle_t   dec, bundle_q;

  logic [5:0] opcode, funct;
  logic [4:0] f_rs, f_rt, f_rd;
  logic       d_legal, d_jump, d_zext;
  logic       use_rs, use_rt, lu_haz;
  logic       take, hold;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign f_rs   = instr[25:21];
  assign f_rt   = instr[20:16];
  assign f_rd   = instr[15:11];

  // Combinational decode of the incoming instruction. An unrecognised
  // encoding leaves every control at its bubble value and only clears d_legal.
  always_comb begin
    d_legal  = 1'b1;
    d_jump   = 1'b0;
    d_zext   = 1'b0;
    dec      = '0;
    dec.valid = 1'b1;
    dec.rs   = f_rs;
    dec.rt   = f_rt;
    dec.ja   = instr[25:0];
    case (opcode)
      OPC_LW:   begin dec.alub = 1'b1; dec.we = 1'b1; dec.dmre = 1'b1;
                      dec.rdin = RD_DM; dec.wa = f_rt; end
      OPC_SW:   begin dec.alub = 1'b1; dec.dmwe = 1'b1; end
      OPC_J:    begin dec.pc = PC_J; d_jump = 1'b1; end
      OPC_JAL:  begin dec.pc = PC_J; dec.we = 1'b1; dec.rdin = RD_JAL;
                      dec.wa = 5'd31; d_jump = 1'b1; end
      OPC_BNE:  begin dec.op = OP_SUB; dec.pc = PC_BNE; end
      OPC_ADDI: begin dec.alub = 1'b1; dec.we = 1'b1; dec.wa = f_rt; end
      OPC_XORI: begin dec.op = OP_XOR; dec.alub = 1'b1; dec.we = 1'b1; dec.wa = f_rt; end
      OPC_ANDI: begin dec.op = OP_AND; dec.alub = 1'b1; dec.we = 1'b1; dec.wa = f_rt;
                      d_zext = 1'b1; end
      OPC_ORI:  begin dec.op = OP_OR; dec.alub = 1'b1; dec.we = 1'b1; dec.wa = f_rt;
                      d_zext = 1'b1; end
      OPC_RTYPE: begin
        dec.we = 1'b1;
        dec.wa = f_rd;
        case (funct)
          FN_ADD, FN_SLL: dec.op = OP_ADD;
          FN_SUB:         dec.op = OP_SUB;
          FN_SLT:         dec.op = OP_SLT;
          FN_AND:         dec.op = OP_AND;
          FN_OR:          dec.op = OP_OR;
          FN_XOR:         dec.op = OP_XOR;
          FN_NOR:         dec.op = OP_NOR;
          FN_JR:   begin dec.we = 1'b0; dec.wa = '0; dec.pc = PC_JR; d_jump = 1'b1; end
          default: begin dec.we = 1'b0; dec.wa = '0; d_legal = 1'b0; end
        endcase
      end
      default: d_legal = 1'b0;
    endcase
    dec.ill = ~d_legal;
    dec.imm = d_zext ? {{(WIDTH-16){1'b0}}, instr[15:0]}
                     : {{(WIDTH-16){instr[15]}}, instr[15:0]};
  end

  // Source-register usage for the load-use interlock.
  assign use_rs = (opcode != OPC_J) && (opcode != OPC_JAL);
  assign use_rt = (opcode == OPC_RTYPE) || (opcode == OPC_SW) || (opcode == OPC_BNE);

  assign lu_haz = instrValid && bundle_q.valid && bundle_q.dmre && (bundle_q.wa != 5'd0) &&
                  ((use_rs && (f_rs == bundle_q.wa)) || (use_rt && (f_rt == bundle_q.wa)));

  assign instrReady = !reset && (flush || (!stall && !lu_haz));

  // Next-state / per-edge action. Anything that is neither held nor taken
  // registers a bubble.
  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    take    = 1'b0;
    if (reset || flush) begin
      state_d = S_RUN;
    end else if (stall) begin
      hold = 1'b1;
    end else if (lu_haz) begin
      take = 1'b0;
    end else if ((state_q == S_SQUASH) && instrValid) begin
      state_d = S_RUN;
    end else if (instrValid) begin
      take    = 1'b1;
      state_d = (SQUASH_EN && d_legal && d_jump) ? S_SQUASH : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      bundle_q <= '0;
    end else begin
      state_q <= state_d;
      if (take)       bundle_q <= dec;
      else if (!hold) bundle_q <= '0;
    end
  end

  assign outValid    = bundle_q.valid;
  assign illegal     = bundle_q.ill;
  assign op          = bundle_q.op;
  assign pcSrcCtrl   = bundle_q.pc;
  assign regDInCtrl  = bundle_q.rdin;
  assign regWe       = bundle_q.we;
  assign dmWe        = bundle_q.dmwe;
  assign dmRe        = bundle_q.dmre;
  assign aluBSrcCtrl = bundle_q.alub;
  assign regWAddr    = bundle_q.wa;
  assign rs          = bundle_q.rs;
  assign rt          = bundle_q.rt;
  assign imm         = bundle_q.imm;
  assign jAddr       = bundle_q.ja;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances share one input stream
// (WIDTH=32/DELAY_SLOT=0 and WIDTH=64/DELAY_SLOT=1). Each is compared
// every cycle against its own behavioural model, after the directed steps.
module tb_decode_stage;

  typedef struct packed {
    logic        ov, il, we, dw, dr, ab;
    logic [2:0]  op;
    logic [1:0]  pc, rdin;
    logic [4:0]  wa, rs, rt;
    logic [63:0] imm;
    logic [25:0] ja;
  } bundle_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, instrValid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] instr = '0;

  logic rdy0, ov0, il0, we0, dw0, dr0, ab0;
  logic [2:0] op0; logic [1:0] pc0, rd0; logic [4:0] wa0, rs0, rt0;
  logic [31:0] imm0; logic [25:0] ja0;
  logic rdy1, ov1, il1, we1, dw1, dr1, ab1;
  logic [2:0] op1; logic [1:0] pc1, rd1; logic [4:0] wa1, rs1, rt1;
  logic [63:0] imm1; logic [25:0] ja1;

  decode_stage #(.WIDTH(32), .DELAY_SLOT(0)) dut0 (
    .clk(clk), .reset(reset), .instr(instr), .instrValid(instrValid), .instrReady(rdy0),
    .stall(stall), .flush(flush), .outValid(ov0), .op(op0), .pcSrcCtrl(pc0),
    .regDInCtrl(rd0), .regWe(we0), .dmWe(dw0), .dmRe(dr0), .aluBSrcCtrl(ab0),
    .regWAddr(wa0), .rs(rs0), .rt(rt0), .imm(imm0), .jAddr(ja0), .illegal(il0));

  decode_stage #(.WIDTH(64), .DELAY_SLOT(1)) dut1 (
    .clk(clk), .reset(reset), .instr(instr), .instrValid(instrValid), .instrReady(rdy1),
    .stall(stall), .flush(flush), .outValid(ov1), .op(op1), .pcSrcCtrl(pc1),
    .regDInCtrl(rd1), .regWe(we1), .dmWe(dw1), .dmRe(dr1), .aluBSrcCtrl(ab1),
    .regWAddr(wa1), .rs(rs1), .rt(rt1), .imm(imm1), .jAddr(ja1), .illegal(il1));

  bundle_t g0, g1, m0, m1;
  logic    sq0 = 1'b0, sq1 = 1'b0;
  logic    rdy0_pre, rdy1_pre;
  int      checks = 0, errors = 0;

  assign g0 = '{ov:ov0, il:il0, we:we0, dw:dw0, dr:dr0, ab:ab0, op:op0, pc:pc0, rdin:rd0,
                wa:wa0, rs:rs0, rt:rt0, imm:{32'b0, imm0}, ja:ja0};
  assign g1 = '{ov:ov1, il:il1, we:we1, dw:dw1, dr:dr1, ab:ab1, op:op1, pc:pc1, rdin:rd1,
                wa:wa1, rs:rs1, rt:rt1, imm:imm1, ja:ja1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the opcode/funct table.
  function automatic bundle_t model_decode(input logic [31:0] i);
    bundle_t b;
    logic [5:0] opc, fn;
    opc = i[31:26];
    fn  = i[5:0];
    b = '0;
    b.ov = 1'b1;
    b.rs = i[25:21];
    b.rt = i[20:16];
    b.ja = i[25:0];
    b.imm = {{48{i[15]}}, i[15:0]};
    case (opc)
      6'h23: begin b.ab = 1; b.we = 1; b.dr = 1; b.rdin = 1; b.wa = i[20:16]; end
      6'h2b: begin b.ab = 1; b.dw = 1; end
      6'h02: b.pc = 1;
      6'h03: begin b.pc = 1; b.we = 1; b.rdin = 2; b.wa = 31; end
      6'h05: begin b.op = 1; b.pc = 3; end
      6'h08: begin b.ab = 1; b.we = 1; b.wa = i[20:16]; end
      6'h0e: begin b.op = 2; b.ab = 1; b.we = 1; b.wa = i[20:16]; end
      6'h0c: begin b.op = 4; b.ab = 1; b.we = 1; b.wa = i[20:16]; b.imm = {48'b0, i[15:0]}; end
      6'h0d: begin b.op = 7; b.ab = 1; b.we = 1; b.wa = i[20:16]; b.imm = {48'b0, i[15:0]}; end
      6'h00: begin
        if (fn == 6'h08) b.pc = 2;
        else begin
          b.we = 1; b.wa = i[15:11];
          case (fn)
            6'h20, 6'h00: b.op = 0;
            6'h22: b.op = 1;
            6'h2a: b.op = 3;
            6'h24: b.op = 4;
            6'h25: b.op = 7;
            6'h26: b.op = 2;
            6'h27: b.op = 6;
            default: b.il = 1;
          endcase
        end
      end
      default: b.il = 1;
    endcase
    if (b.il) begin
      b = '0;
      b.ov = 1;
      b.il = 1;
    end
    return b;
  endfunction

  function automatic logic is_jump(input logic [31:0] i);
    return (i[31:26] == 6'h02) || (i[31:26] == 6'h03) || (i[31:26] == 6'h00 && i[5:0] == 6'h08);
  endfunction

  function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
    logic [5:0] opc;
    opc = i[31:26];
    return ((opc != 6'h02) && (opc != 6'h03) && (i[25:21] == r)) ||
           (((opc == 6'h00) || (opc == 6'h2b) || (opc == 6'h05)) && (i[20:16] == r));
  endfunction

  function automatic logic m_haz(input bundle_t m);
    return instrValid && m.ov && m.dr && (m.wa != 0) && reads(instr, m.wa);
  endfunction

  task automatic model_edge(inout bundle_t m, inout logic sq, input bit ds1);
    logic haz;
    haz = m_haz(m);
    if (reset || flush) begin m = '0; sq = 0; end
    else if (stall) begin end
    else if (haz) m = '0;
    else if (sq && instrValid) begin m = '0; sq = 0; end
    else if (instrValid) begin
      m  = model_decode(instr);
      sq = !ds1 && !m.il && is_jump(instr);
    end else m = '0;
  endtask

  task automatic check_dut(input string p, input bundle_t m, input bundle_t g, input bit w64);
    logic [63:0] mi;
    mi = w64 ? m.imm : {32'b0, m.imm[31:0]};
    chk({p, "_outValid"}, g.ov, m.ov);
    chk({p, "_illegal"}, g.il, m.il);
    chk({p, "_regWe"}, g.we, m.we);
    chk({p, "_dmWe"}, g.dw, m.dw);
    chk({p, "_dmRe"}, g.dr, m.dr);
    chk({p, "_pcSrc"}, g.pc, m.pc);
    chk({p, "_op"}, g.op, m.op);
    if (m.ov && !m.il) begin
      chk({p, "_regDIn"}, g.rdin, m.rdin);
      chk({p, "_aluB"}, g.ab, m.ab);
      chk({p, "_rs"}, g.rs, m.rs);
      chk({p, "_rt"}, g.rt, m.rt);
      chk({p, "_jAddr"}, g.ja, m.ja);
      chk({p, "_imm"}, g.imm, mi);
      if (m.we) chk({p, "_regWAddr"}, g.wa, m.wa);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [31:0] i,
                       input logic s, input logic f);
    logic e0, e1;
    reset = r; instrValid = v; instr = i; stall = s; flush = f;
    #1;
    e0 = !reset && (flush || (!stall && !m_haz(m0)));
    e1 = !reset && (flush || (!stall && !m_haz(m1)));
    rdy0_pre = rdy0;
    rdy1_pre = rdy1;
    chk("d0_instrReady", rdy0, e0);
    chk("d1_instrReady", rdy1, e1);
    @(posedge clk);
    model_edge(m0, sq0, 1'b0);
    model_edge(m1, sq1, 1'b1);
    #1;
    check_dut("d0", m0, g0, 1'b0);
    check_dut("d1", m1, g1, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fl [8];
    logic [4:0] a, b, c;
    logic [15:0] im;
    int k;
    fl = '{6'h20, 6'h00, 6'h22, 6'h2a, 6'h24, 6'h25, 6'h26, 6'h27};
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    k = $urandom_range(0, 13);
    case (k)
      0:  return {6'h23, a, b, im};
      1:  return {6'h2b, a, b, im};
      2:  return {6'h02, 26'($urandom)};
      3:  return {6'h03, 26'($urandom)};
      4:  return {6'h05, a, b, im};
      5:  return {6'h08, a, b, im};
      6:  return {6'h0e, a, b, im};
      7:  return {6'h0c, a, b, im};
      8:  return {6'h0d, a, b, im};
      9:  return {6'h00, a, b, c, 5'd0, fl[$urandom_range(0, 7)]};
      10: return {6'h00, a, 5'd0, 5'd0, 5'd0, 6'h08};
      11: return {6'h00, a, b, c, 5'd0, 6'($urandom)};
      12: return {6'($urandom), a, b, im};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m0 = '0;
    m1 = '0;
    @(negedge clk);

    // reset held two cycles with a valid LW presented
    cycle(1, 1, 32'h8C080004, 0, 0);
    cycle(1, 1, 32'h8C080004, 0, 0);
    chk("rst_ctl", {ov0, il0, we0, dw0, dr0, ab0, op0, pc0, rd0, wa0, rs0, rt0}, '0);
    chk("rst_imm", imm0, 0);
    chk("rst_imm64", imm1, 0);
    chk("rst_jaddr", ja0, 0);
    chk("rst_rdy", rdy0_pre, 0);
    cycle(0, 1, 32'h8C080004, 0, 0);
    chk("lw_ctl", {we0, dr0, rd0, wa0}, {1'b1, 1'b1, 2'd1, 5'd8});
    chk("lw_imm", imm0, 4);

    // load-use: LW $8,0($9) then ADD $10,$8,$11
    cycle(0, 1, 32'h8D280000, 0, 0);
    cycle(0, 1, 32'h010B5020, 0, 0);
    chk("lu_rdy", rdy0_pre, 0);
    chk("lu_bubble", ov0, 0);
    cycle(0, 1, 32'h010B5020, 0, 0);
    chk("lu_rdy2", rdy0_pre, 1);
    chk("lu_add", {ov0, op0, wa0}, {1'b1, 3'd0, 5'd10});
    // LW to $0 never interlocks
    cycle(0, 1, 32'h8C000004, 0, 0);
    cycle(0, 1, 32'h000B5020, 0, 0);
    chk("lu0_rdy", rdy0_pre, 1);
    chk("lu0_add", {ov0, wa0}, {1'b1, 5'd10});

    // jump squash vs delay slot
    cycle(0, 1, 32'h08000010, 0, 0);
    chk("j_addr", ja0, 26'h10);
    chk("j_pc", pc0, 1);
    cycle(0, 1, 32'h20010001, 0, 0);
    chk("j_squash", ov0, 0);
    chk("j_slot", ov1, 1);
    cycle(0, 1, 32'h20020002, 0, 0);
    chk("j_next", {ov0, wa0}, {1'b1, 5'd2});
    chk("j_next64", {ov1, wa1}, {1'b1, 5'd2});

    // immediates
    cycle(0, 1, 32'h30038001, 0, 0);
    chk("andi_imm", imm0, 32'h00008001);
    cycle(0, 1, 32'h20038001, 0, 0);
    chk("addi_imm", imm0, 32'hFFFF8001);
    chk("addi_imm64", imm1, 64'hFFFFFFFFFFFF8001);

    // stall with SW registered, then flush+stall
    cycle(0, 1, 32'hACA40008, 0, 0);
    for (int n = 0; n < 3; n++) begin
      cycle(0, 1, 32'h20010001, 1, 0);
      chk("stall_rdy", rdy0_pre, 0);
      chk("stall_sw", {ov0, dw0, imm0}, {1'b1, 1'b1, 32'd8});
    end
    cycle(0, 1, 32'h20010001, 1, 1);
    chk("flush_rdy", rdy0_pre, 1);
    chk("flush_bubble", ov0, 0);

    // illegal opcode, illegal funct, then a legal one
    cycle(0, 1, 32'hFC000000, 0, 0);
    chk("ill_opc", {il0, ov0, we0, dw0}, 4'b1100);
    cycle(0, 1, 32'h00000001, 0, 0);
    chk("ill_fn", {il0, ov0, we0, dw0}, 4'b1100);
    cycle(0, 1, 32'h000B5020, 0, 0);
    chk("ill_clear", {il0, ov0}, 2'b01);

    // randomized traffic against the models
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75, rand_instr(),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
